cpu_seq: RTL and testbench

Multi-cycle control sequencer for the 8-bit CPU. It fetches 8-bit instructions from instruction memory using a req/ack handshake, then holds them in an instruction register. It presents the opcode nibble to the opcode decoder and issues one-cycle execute and writeback strobes per instruction class. It owns the program counter, executes JMP and HALT itself, and keeps a retired-instruction counter.

---
 rtl/cpu_seq_if.sv | 24 ++
 rtl/cpu_seq.sv | 125 ++++++++++++
 tb/tb_cpu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_if.sv
// Instruction-memory fetch channel between the CPU sequencer and instruction memory.
// The sequencer drives req/addr; memory answers with ack/data.
interface cpu_seq_if #(
    parameter int PC_W = 8
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
// Owns the PC, handles JMP/HALT locally and counts retired instructions.
module cpu_seq #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stop,
    cpu_seq_if.master        imem,
    output logic [3:0]       op,
    output logic [3:0]       imm,
    output logic             alu_en,
    output logic             reg_we,
    output logic             out_we,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [7:0]       ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;
    logic             req_q, req_d;
    logic             alu_q, alu_d;
    logic             reg_q, reg_d;
    logic             out_q, out_d;
    logic             halted_q, halted_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_q[7:4] == 4'hF) begin
                    state_d = S_HALT;
                    cnt_inc = 1'b1;
                end else if (ir_q[7:4] == 4'hE) begin
                    // pc already points past the JMP; only its low nibble is replaced
                    pc_d    = {pc_q[PC_W-1:4], ir_q[3:0]};
                    state_d = S_FETCH;
                    cnt_inc = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                cnt_inc = 1'b1;
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        cnt_d = (cnt_inc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

        // Strobes are decoded from the next state so they come straight out of flops
        req_d    = (state_d == S_FETCH);
        alu_d    = (state_d == S_EXEC) && !ir_q[7];
        reg_d    = (state_d == S_WB) && (ir_q[7:4] <= 4'hA);
        out_d    = (state_d == S_WB) && (ir_q[7:4] >= 4'hB) && (ir_q[7:4] <= 4'hD);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            alu_q    <= 1'b0;
            reg_q    <= 1'b0;
            out_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            alu_q    <= alu_d;
            reg_q    <= reg_d;
            out_q    <= out_d;
            halted_q <= halted_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign op             = ir_q[7:4];
    assign imm            = ir_q[3:0];
    assign alu_en         = alu_q;
    assign reg_we         = reg_q;
    assign out_we         = out_q;
    assign halted         = halted_q;
    assign state          = state_q;
    assign instr_cnt      = cnt_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Randomized self-checking bench for cpu_seq against an instruction-level reference model.
module tb_cpu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        run, stop;
    logic [3:0]  op, imm;
    logic        alu_en, reg_we, out_we, halted;
    logic [2:0]  state;
    logic [15:0] instr_cnt;

    logic        run2, stop2;
    logic [3:0]  op2, imm2;
    logic        alu_en2, reg_we2, out_we2, halted2;
    logic [2:0]  state2;
    logic [2:0]  instr_cnt2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_cnt;

    cpu_seq_if #(.PC_W(8)) bus ();
    cpu_seq_if #(.PC_W(5)) bus2 ();

    cpu_seq #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(rst), .run(run), .stop(stop), .imem(bus),
        .op(op), .imm(imm), .alu_en(alu_en), .reg_we(reg_we), .out_we(out_we),
        .halted(halted), .state(state), .instr_cnt(instr_cnt)
    );

    cpu_seq #(.PC_W(5), .CNT_W(3)) dut_small (
        .clk(clk), .reset(rst), .run(run2), .stop(stop2), .imem(bus2),
        .op(op2), .imm(imm2), .alu_en(alu_en2), .reg_we(reg_we2), .out_we(out_we2),
        .halted(halted2), .state(state2), .instr_cnt(instr_cnt2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc  = 8'h00;
        m_cnt = 16'h0000;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Runs one instruction from mem[m_pc], starting at a negedge where a fetch is expected.
    task automatic step(input int d, input bit stp);
        logic [7:0] ins;
        logic [3:0] eop, eimm;
        int k, na, nr, no, ek;
        bit timeout;
        ins  = mem[m_pc];
        eop  = ins[7:4];
        eimm = ins[3:0];
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_start req=%b addr=%h, want req=1 addr=%h", bus.imem_req, bus.imem_addr, m_pc);
        end
        for (int i = 0; i < d; i++) begin
            bus.imem_ack = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
                errors++;
                $display("FAIL fetch_hold req=%b addr=%h, want req=1 addr=%h", bus.imem_req, bus.imem_addr, m_pc);
            end
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = ins;
        stop = stp;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'($urandom);

        if (eop == 4'hE) m_pc = ((m_pc + 8'd1) & 8'hF0) | {4'h0, eimm};
        else             m_pc = m_pc + 8'd1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        ek = (eop >= 4'hE) ? 1 : 3;

        k = 0; na = 0; nr = 0; no = 0; timeout = 0;
        while (!(bus.imem_req === 1'b1 || halted === 1'b1 || state === 3'd0)) begin
            if (alu_en) na++;
            if (reg_we) nr++;
            if (out_we) no++;
            checks++;
            if (op !== eop || imm !== eimm || $countones({bus.imem_req, alu_en, reg_we, out_we}) > 1) begin
                errors++;
                $display("FAIL decode_hold op=%h imm=%h strobes=%b, want op=%h imm=%h one-hot",
                         op, imm, {bus.imem_req, alu_en, reg_we, out_we}, eop, eimm);
            end
            k++;
            if (k > 8) begin timeout = 1; break; end
            @(negedge clk);
        end
        stop = 1'b0;

        checks++;
        if (timeout || k != ek) begin
            errors++;
            $display("FAIL latency op=%h cycles=%0d timeout=%0d, want %0d", eop, k, timeout, ek);
        end
        checks++;
        if (na != ((eop <= 4'h7) ? 1 : 0) || nr != ((eop <= 4'hA) ? 1 : 0) ||
            no != ((eop >= 4'hB && eop <= 4'hD) ? 1 : 0)) begin
            errors++;
            $display("FAIL strobes op=%h alu=%0d reg=%0d out=%0d", eop, na, nr, no);
        end
        checks++;
        if (instr_cnt !== m_cnt) begin
            errors++;
            $display("FAIL instr_cnt got %h want %h", instr_cnt, m_cnt);
        end
        checks++;
        if (bus.imem_addr !== m_pc) begin
            errors++;
            $display("FAIL next_pc got %h want %h", bus.imem_addr, m_pc);
        end
        checks++;
        if (eop == 4'hF) begin
            if (halted !== 1'b1 || bus.imem_req !== 1'b0 || state !== 3'd5) begin
                errors++;
                $display("FAIL end_halt halted=%b req=%b state=%0d, want 1 0 5", halted, bus.imem_req, state);
            end
        end else if (stp && eop <= 4'hD) begin
            if (state !== 3'd0 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL end_stop state=%0d req=%b, want 0 0", state, bus.imem_req);
            end
        end else begin
            if (state !== 3'd1 || bus.imem_req !== 1'b1) begin
                errors++;
                $display("FAIL end_fetch state=%0d req=%b, want 1 1", state, bus.imem_req);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if (state !== 3'd0 || bus.imem_addr !== 8'h00 || instr_cnt !== 16'h0 || op !== 4'h0 || imm !== 4'h0 ||
            {bus.imem_req, alu_en, reg_we, out_we, halted} !== 5'b0) begin
            errors++;
            $display("FAIL reset state=%0d addr=%h cnt=%h ir=%h%h ctl=%b, want all zero", state, bus.imem_addr,
                     instr_cnt, op, imm, {bus.imem_req, alu_en, reg_we, out_we, halted});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait state=%0d req=%b, want 0 0", state, bus.imem_req);
        end
    endtask

    task automatic test_alu_first();
        mem[0] = 8'h05;
        pulse_run();
        step(0, 1'b0);
    endtask

    task automatic test_out_delayed();
        mem[1] = 8'hB5;
        step(3, 1'b0);
    endtask

    task automatic test_jmp();
        mem[2]    = 8'hEF;
        mem[8'h0F] = 8'hE3;
        mem[8'h13] = 8'hEF;
        mem[8'h1F] = 8'hE2;
        for (int i = 0; i < 4; i++) step(i % 2, 1'b1);
        checks++;
        if (bus.imem_addr !== 8'h22) begin
            errors++;
            $display("FAIL jmp_chain addr=%h want 22", bus.imem_addr);
        end
    endtask

    task automatic test_stop();
        mem[8'h22] = 8'h3A;
        step(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h23) begin
                errors++;
                $display("FAIL stop_idle state=%0d req=%b addr=%h, want 0 0 23", state, bus.imem_req, bus.imem_addr);
            end
        end
        mem[8'h23] = 8'hC7;
        pulse_run();
        step(0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] ins;
        for (int n = 0; n < 40; n++) begin
            if (state === 3'd0) pulse_run();
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF) ins[7:4] = 4'h0;
            mem[m_pc] = ins;
            step(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_halt();
        logic [7:0] hpc;
        if (state === 3'd0) pulse_run();
        mem[m_pc] = 8'hF0;
        step(1, 1'b0);
        hpc = m_pc;
        for (int i = 0; i < 10; i++) begin
            run  = 1'($urandom);
            stop = 1'($urandom);
            bus.imem_ack = 1'($urandom);
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.imem_addr !== hpc || state !== 3'd5 ||
                {alu_en, reg_we, out_we} !== 3'b0) begin
                errors++;
                $display("FAIL halt_hold halted=%b req=%b addr=%h state=%0d, want 1 0 %h 5", halted,
                         bus.imem_req, bus.imem_addr, state, hpc);
            end
        end
        run = 1'b0; stop = 1'b0; bus.imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || state !== 3'd0 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL halt_reset halted=%b state=%0d addr=%h, want 0 0 00", halted, state, bus.imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_midfetch();
        mem[0] = 8'h11;
        pulse_run();
        step(0, 1'b0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
            errors++;
            $display("FAIL midfetch_pre req=%b addr=%h, want 1 01", bus.imem_req, bus.imem_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || state !== 3'd0 || bus.imem_addr !== 8'h00 || instr_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midfetch_reset req=%b state=%0d addr=%h cnt=%h, want all zero", bus.imem_req, state,
                     bus.imem_addr, instr_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hE5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || bus.imem_req !== 1'b0 || op !== 4'h0 || bus.imem_addr !== 8'h00) begin
                errors++;
                $display("FAIL late_ack state=%0d req=%b op=%h addr=%h, want 0 0 0 00", state, bus.imem_req, op,
                         bus.imem_addr);
            end
        end
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_saturate();
        int n;
        int cyc;
        logic [2:0] ecnt;
        n = 0;
        cyc = 0;
        run2 = 1'b1;
        while (n < 40 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (reg_we2 === 1'b1) begin
                n++;
                ecnt = (n - 1 > 7) ? 3'd7 : 3'(n - 1);
                checks++;
                if (instr_cnt2 !== ecnt) begin
                    errors++;
                    $display("FAIL sat_cnt instr=%0d got %0d want %0d", n, instr_cnt2, ecnt);
                end
            end
        end
        run2 = 1'b0;
        checks++;
        if (n != 40 || bus2.imem_addr !== 5'd8) begin
            errors++;
            $display("FAIL sat_wrap retired=%0d addr=%0d, want 40 8", n, bus2.imem_addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0; stop = 1'b0;
        run2 = 1'b0; stop2 = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
        bus2.imem_ack = 1'b1; bus2.imem_data = 8'h21;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'h1;
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_alu_first();
        test_out_delayed();
        test_jmp();
        test_stop();
        test_random();
        test_halt();
        test_reset_midfetch();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
